// File: rtl/uart_echo_tester.sv
// Host-side self-test for the UART echo path: pushes a counting byte sequence
// through the TX FIFO one byte at a time and checks each echo from the RX FIFO.
module uart_echo_tester #(
    parameter int         NUM_BYTES      = 256,
    parameter logic [7:0] START_VALUE    = 8'h00,
    parameter int         TIMEOUT_CYCLES = 1200000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    output logic [7:0]  tx_byte,
    output logic        transmit,
    input  logic        tx_fifo_full,
    input  logic [7:0]  rx_byte,
    input  logic        rx_fifo_empty,
    output logic        rx_fifo_pop,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [15:0] err_count
);

    localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BYTES - 1);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_GAP,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [7:0]       r_seq;
    logic [IDX_W-1:0] r_index;
    logic [TMR_W-1:0] r_timer;
    logic [7:0]       r_tx_byte;
    logic             r_transmit;
    logic             r_pop;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic             r_timeout;
    logic [15:0]      r_err_count;

    // NOTE: every output comes straight from a flop so the FIFO strobes are glitch-free.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state     <= S_IDLE;
            r_seq       <= '0;
            r_index     <= '0;
            r_timer     <= '0;
            r_tx_byte   <= '0;
            r_transmit  <= 1'b0;
            r_pop       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_err_count <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (START) begin
                        r_state     <= S_SEND;
                        r_seq       <= START_VALUE;
                        r_index     <= '0;
                        r_err_count <= '0;
                        r_timeout   <= 1'b0;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (!tx_fifo_full) begin
                        r_tx_byte  <= r_seq;
                        r_transmit <= 1'b1;
                        r_timer    <= '0;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // The strobe cycle counts as timer 0, so the abort lands
                    // TIMEOUT_CYCLES+1 cycles after the push.
                    r_transmit <= 1'b0;
                    r_tx_byte  <= '0;
                    r_timer    <= r_timer + TMR_W'(1);
                    if (!rx_fifo_empty) begin
                        if (rx_byte != r_seq && r_err_count != 16'hFFFF)
                            r_err_count <= r_err_count + 16'd1;
                        r_pop   <= 1'b1;
                        r_state <= S_GAP;
                    end else if (r_timer == TMR_LIMIT) begin
                        r_timeout <= 1'b1;
                        r_done    <= 1'b1;
                        r_pass    <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= S_DONE;
                    end
                end
                S_GAP: begin
                    r_pop <= 1'b0;
                    if (r_index == LAST_IDX) begin
                        r_done  <= 1'b1;
                        r_pass  <= (r_err_count == 16'd0) && !r_timeout;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_seq   <= r_seq + 8'd1;
                        r_index <= r_index + IDX_W'(1);
                        r_state <= S_SEND;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tx_byte     = r_tx_byte;
    assign transmit    = r_transmit;
    assign rx_fifo_pop = r_pop;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign timeout     = r_timeout;
    assign err_count   = r_err_count;

endmodule

// File: tb/tb_uart_echo_tester.sv
// Bench for uart_echo_tester: a loopback FIFO model with random echo delays and
// optional corruption, checked against the expected counting sequence.
module tb_uart_echo_tester;

    localparam int         NB = 258;
    localparam logic [7:0] SV = 8'hFF;
    localparam int         TO = 50;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        tx_fifo_full;
    logic        rx_fifo_empty;
    logic [7:0]  rx_byte;
    logic [7:0]  tx_byte;
    logic        transmit;
    logic        rx_fifo_pop;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [15:0] err_count;

    always #5 clk = ~clk;

    uart_echo_tester #(
        .NUM_BYTES(NB),
        .START_VALUE(SV),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK(clk),
        .RESET(rst_n),
        .START(start),
        .tx_byte(tx_byte),
        .transmit(transmit),
        .tx_fifo_full(tx_fifo_full),
        .rx_byte(rx_byte),
        .rx_fifo_empty(rx_fifo_empty),
        .rx_fifo_pop(rx_fifo_pop),
        .busy(busy),
        .done(done),
        .pass(pass),
        .timeout(timeout),
        .err_count(err_count)
    );

    typedef struct {
        logic [7:0] b;
        int         due;
    } echo_t;

    int         n_vec = 0;
    int         n_miss = 0;
    echo_t      pend[$];
    logic [7:0] rxq[$];
    logic [7:0] tx_log[$];
    bit         echo_en = 1'b1;
    bit         corrupt_mask[NB];
    int         n_tx = 0;
    int         n_pop = 0;
    int         n_viol = 0;
    int         cyc = 0;
    bit         prev_tx = 1'b0;
    bit         prev_pop = 1'b0;

    // Far-end loopback plus RX FIFO, sampled and driven on the falling edge.
    initial begin
        rx_fifo_empty = 1'b1;
        rx_byte = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            if (transmit && rx_fifo_pop) n_viol++;
            if (transmit && prev_tx) n_viol++;
            if (rx_fifo_pop && prev_pop) n_viol++;
            prev_tx = transmit;
            prev_pop = rx_fifo_pop;
            if (rx_fifo_pop) begin
                n_pop++;
                if (rxq.size() > 0) void'(rxq.pop_front());
                else n_viol++;
            end
            if (transmit) begin
                if (echo_en) begin
                    echo_t e;
                    e.b = (n_tx < NB && corrupt_mask[n_tx]) ? (tx_byte ^ 8'h01) : tx_byte;
                    e.due = cyc + int'($urandom_range(40, 1));
                    pend.push_back(e);
                end
                tx_log.push_back(tx_byte);
                n_tx++;
            end
            while (pend.size() > 0 && pend[0].due <= cyc) begin
                echo_t t;
                t = pend.pop_front();
                rxq.push_back(t.b);
            end
            rx_fifo_empty = (rxq.size() == 0);
            rx_byte = rx_fifo_empty ? 8'($urandom) : rxq[0];
        end
    end

    task automatic reset_model();
        @(posedge clk);
        #1;
        pend.delete();
        rxq.delete();
        tx_log.delete();
        for (int i = 0; i < NB; i++) corrupt_mask[i] = 1'b0;
        echo_en = 1'b1;
        n_tx = 0;
        n_pop = 0;
        n_viol = 0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int waited);
        waited = 0;
        while (done !== 1'b1 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic check_sequence(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < NB; i++)
            if (i >= tx_log.size() || tx_log[i] !== 8'(int'(SV) + i)) bad++;
        n_vec++;
        if (bad != 0) begin
            n_miss++;
            $display("FAIL %s_seq: %0d of %0d sent bytes wrong (sent %0d), required 0 wrong", tag, bad, NB, tx_log.size());
        end
        n_vec++;
        if (tx_log.size() < NB || tx_log[1] !== 8'h00 || tx_log[256] !== 8'hFF || tx_log[NB-1] !== 8'h00) begin
            n_miss++;
            $display("FAIL %s_wrap: wrap points wrong (sent %0d bytes), required 00 at 1, FF at 256, 00 at %0d", tag, tx_log.size(), NB - 1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        tx_fifo_full = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({tx_byte, transmit, rx_fifo_pop, busy, done, pass, timeout, err_count} !== 30'd0) begin
            n_miss++;
            $display("FAIL reset_outputs: got %h required 0", {tx_byte, transmit, rx_fifo_pop, busy, done, pass, timeout, err_count});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || transmit !== 1'b0) begin
            n_miss++;
            $display("FAIL idle_quiet: busy=%b transmit=%b required 0/0", busy, transmit);
        end
    endtask

    task automatic test_pass_run();
        int w;
        reset_model();
        pulse_start();
        n_vec++;
        if (busy !== 1'b1 || transmit !== 1'b0) begin
            n_miss++;
            $display("FAIL start_latency_send: busy=%b transmit=%b required 1/0", busy, transmit);
        end
        @(negedge clk);
        n_vec++;
        if (transmit !== 1'b1 || tx_byte !== SV) begin
            n_miss++;
            $display("FAIL start_latency_push: transmit=%b tx_byte=%h required 1/%h", transmit, tx_byte, SV);
        end
        @(negedge clk);
        n_vec++;
        if (transmit !== 1'b0 || tx_byte !== 8'h00) begin
            n_miss++;
            $display("FAIL strobe_clear: transmit=%b tx_byte=%h required 0/00", transmit, tx_byte);
        end
        repeat (50) @(negedge clk);
        pulse_start();
        wait_done(NB * 60, w);
        n_vec++;
        if (done !== 1'b1) begin
            n_miss++;
            $display("FAIL pass_run_done: done=%b after %0d cycles, required 1", done, w);
        end
        repeat (5) @(negedge clk);
        n_vec++;
        if ({done, busy, pass, timeout, err_count} !== {4'b1010, 16'd0}) begin
            n_miss++;
            $display("FAIL pass_run_status: done/busy/pass/timeout=%b%b%b%b err=%0d required 1010/0", done, busy, pass, timeout, err_count);
        end
        n_vec++;
        if (n_tx != NB || n_pop != NB || n_viol != 0) begin
            n_miss++;
            $display("FAIL pass_run_pulses: tx=%0d pop=%0d viol=%0d required %0d/%0d/0", n_tx, n_pop, n_viol, NB, NB);
        end
        check_sequence("pass_run");
    endtask

    task automatic test_mismatch();
        int w;
        int exp_err;
        reset_model();
        corrupt_mask[2] = 1'b1;
        repeat (int'($urandom_range(4, 0))) corrupt_mask[$urandom_range(NB - 1, 0)] = 1'b1;
        exp_err = 0;
        for (int i = 0; i < NB; i++) if (corrupt_mask[i]) exp_err++;
        pulse_start();
        wait_done(NB * 60, w);
        repeat (3) @(negedge clk);
        n_vec++;
        if (done !== 1'b1 || err_count !== 16'(exp_err)) begin
            n_miss++;
            $display("FAIL mismatch_count: done=%b err=%0d required 1/%0d", done, err_count, exp_err);
        end
        n_vec++;
        if (pass !== 1'b0 || timeout !== 1'b0) begin
            n_miss++;
            $display("FAIL mismatch_flags: pass=%b timeout=%b required 0/0", pass, timeout);
        end
        n_vec++;
        if (n_tx != NB || n_pop != NB || n_viol != 0) begin
            n_miss++;
            $display("FAIL mismatch_pulses: tx=%0d pop=%0d viol=%0d required %0d/%0d/0", n_tx, n_pop, n_viol, NB, NB);
        end
    endtask

    task automatic test_timeout();
        int w;
        int k;
        reset_model();
        echo_en = 1'b0;
        pulse_start();
        w = 0;
        while (transmit !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        k = 0;
        while (done !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (k != TO + 1) begin
            n_miss++;
            $display("FAIL timeout_latency: done after %0d cycles required %0d", k, TO + 1);
        end
        n_vec++;
        if (timeout !== 1'b1 || pass !== 1'b0 || busy !== 1'b0) begin
            n_miss++;
            $display("FAIL timeout_flags: timeout=%b pass=%b busy=%b required 1/0/0", timeout, pass, busy);
        end
        rxq.push_back(8'h00);
        repeat (10) @(negedge clk);
        n_vec++;
        if (n_tx != 1 || n_pop != 0 || done !== 1'b1) begin
            n_miss++;
            $display("FAIL timeout_no_pop: tx=%0d pop=%0d done=%b required 1/0/1", n_tx, n_pop, done);
        end
    endtask

    task automatic test_fifo_full_and_reset();
        int bad;
        int seen;
        int w;
        reset_model();
        tx_fifo_full = 1'b1;
        pulse_start();
        n_vec++;
        if (done !== 1'b0 || err_count !== 16'd0 || timeout !== 1'b0) begin
            n_miss++;
            $display("FAIL restart_clear: done=%b err=%0d timeout=%b required 0/0/0", done, err_count, timeout);
        end
        bad = 0;
        repeat (10) begin
            if (transmit !== 1'b0) bad++;
            @(negedge clk);
        end
        n_vec++;
        if (bad != 0 || busy !== 1'b1) begin
            n_miss++;
            $display("FAIL full_hold: %0d pushes while full, busy=%b required 0/1", bad, busy);
        end
        tx_fifo_full = 1'b0;
        @(negedge clk);
        n_vec++;
        if (transmit !== 1'b1 || tx_byte !== SV) begin
            n_miss++;
            $display("FAIL full_release: transmit=%b tx_byte=%h required 1/%h", transmit, tx_byte, SV);
        end
        seen = 1;
        w = 0;
        while (seen < 2 && w < 200) begin
            @(negedge clk);
            w++;
            if (transmit === 1'b1) seen++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_vec++;
        if ({tx_byte, transmit, rx_fifo_pop, busy, done, pass, timeout, err_count} !== 30'd0 || seen != 2) begin
            n_miss++;
            $display("FAIL midrun_reset: got %h (pushes seen %0d) required 0 after 2 pushes", {tx_byte, transmit, rx_fifo_pop, busy, done, pass, timeout, err_count}, seen);
        end
        repeat (50) @(negedge clk);
        reset_model();
        pulse_start();
        @(negedge clk);
        n_vec++;
        if (transmit !== 1'b1 || tx_byte !== SV) begin
            n_miss++;
            $display("FAIL rerun_first: transmit=%b tx_byte=%h required 1/%h", transmit, tx_byte, SV);
        end
        wait_done(NB * 60, w);
        repeat (3) @(negedge clk);
        n_vec++;
        if (done !== 1'b1 || pass !== 1'b1 || err_count !== 16'd0 || n_tx != NB) begin
            n_miss++;
            $display("FAIL rerun_status: done=%b pass=%b err=%0d tx=%0d required 1/1/0/%0d", done, pass, err_count, n_tx, NB);
        end
        check_sequence("rerun");
    endtask

    initial begin
        test_reset();
        test_pass_run();
        test_mismatch();
        test_timeout();
        test_fifo_full_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
